// File: rtl/nx_indirect_access_ram_arb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | nx_indirect_access_ram_arb: single-port RAM arbiter, HW port vs SW port  |
// | with anti-starvation burst limit and registered compare result.          |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module nx_indirect_access_ram_arb #(
  parameter int N_DATA_BITS  = 96,
  parameter int N_ADDR_BITS  = 9,
  parameter int HW_BURST_MAX = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   sw_cs,
  input  logic                   sw_ce,
  input  logic                   sw_we,
  input  logic [N_ADDR_BITS-1:0] sw_add,
  input  logic [N_DATA_BITS-1:0] sw_wdat,
  output logic [N_DATA_BITS-1:0] sw_rdat,
  output logic                   sw_match,
  output logic [7:0]             sw_aindex,
  output logic                   grant,
  input  logic                   yield,
  input  logic                   reset,
  input  logic                   hw_req,
  input  logic                   hw_we,
  input  logic [N_ADDR_BITS-1:0] hw_addr,
  input  logic [N_DATA_BITS-1:0] hw_wdat,
  output logic                   hw_gnt,
  output logic                   hw_rvalid,
  output logic [N_DATA_BITS-1:0] hw_rdat,
  output logic                   ram_cs,
  output logic                   ram_we,
  output logic [N_ADDR_BITS-1:0] ram_addr,
  output logic [N_DATA_BITS-1:0] ram_wdat,
  input  logic [N_DATA_BITS-1:0] ram_rdat
);

  localparam int CNT_W = $clog2(HW_BURST_MAX + 1);
  localparam logic [CNT_W-1:0] C_BURST_MAX = CNT_W'(HW_BURST_MAX);

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_SW   = 2'd1,
    TAG_CMP  = 2'd2,
    TAG_HW   = 2'd3
  } tag_t;

  tag_t                   r_tag;
  tag_t                   w_tag_nxt;
  logic [CNT_W-1:0]       r_burst_cnt;
  logic [N_DATA_BITS-1:0] r_sw_rdat;
  logic [N_DATA_BITS-1:0] r_hw_rdat;
  logic [N_DATA_BITS-1:0] r_cmp_data;
  logic [7:0]             r_cmp_idx;
  logic                   r_match;
  logic [7:0]             r_aindex;
  logic                   w_sel_sw;
  logic                   w_ret_sw;
  logic                   w_ret_cmp;
  logic                   w_ret_hw;

  assign w_sel_sw = sw_cs & (~hw_req | yield | reset | (r_burst_cnt == C_BURST_MAX));
  assign grant    = rst_n & w_sel_sw;
  assign hw_gnt   = rst_n & hw_req & ~w_sel_sw;

  assign ram_cs   = grant | hw_gnt;
  assign ram_we   = grant ? (sw_we & ~sw_ce) : (hw_gnt & hw_we);
  assign ram_addr = grant ? sw_add  : hw_addr;
  assign ram_wdat = grant ? sw_wdat : hw_wdat;

  // Return strobes are gated by rst_n so a reset in the data cycle suppresses them.
  assign w_ret_sw  = rst_n & (r_tag == TAG_SW);
  assign w_ret_cmp = rst_n & (r_tag == TAG_CMP);
  assign w_ret_hw  = rst_n & (r_tag == TAG_HW);

  assign sw_rdat   = w_ret_sw ? ram_rdat : r_sw_rdat;
  assign hw_rvalid = w_ret_hw;
  assign hw_rdat   = w_ret_hw ? ram_rdat : r_hw_rdat;
  assign sw_match  = r_match;
  assign sw_aindex = r_aindex;

  always_comb begin
    w_tag_nxt = TAG_NONE;
    if (grant && !sw_we) begin
      w_tag_nxt = sw_ce ? TAG_CMP : TAG_SW;
    end else if (hw_gnt && !hw_we) begin
      w_tag_nxt = TAG_HW;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_tag <= TAG_NONE;
    end else begin
      r_tag <= w_tag_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_burst_cnt <= '0;
    end else if (grant || !sw_cs) begin
      r_burst_cnt <= '0;
    end else if (hw_gnt && (r_burst_cnt != C_BURST_MAX)) begin
      r_burst_cnt <= r_burst_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sw_rdat  <= '0;
      r_hw_rdat  <= '0;
      r_cmp_data <= '0;
      r_cmp_idx  <= '0;
      r_match    <= 1'b0;
      r_aindex   <= '0;
    end else begin
      if (grant && sw_ce && !sw_we) begin
        r_cmp_data <= sw_wdat;
        r_cmp_idx  <= sw_add[7:0];
      end
      if (w_ret_sw) begin
        r_sw_rdat <= ram_rdat;
      end
      if (w_ret_hw) begin
        r_hw_rdat <= ram_rdat;
      end
      if (w_ret_cmp) begin
        r_match  <= (ram_rdat == r_cmp_data);
        r_aindex <= r_cmp_idx;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_nx_indirect_access_ram_arb.sv
`default_nettype none
// Scoreboard bench for nx_indirect_access_ram_arb with a behavioural 1-cycle RAM.
module tb_nx_indirect_access_ram_arb;
  localparam int DW = 96;
  localparam int AW = 9;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sw_cs = 0, sw_ce = 0, sw_we = 0;
  logic [AW-1:0] sw_add = '0;
  logic [DW-1:0] sw_wdat = '0;
  logic [DW-1:0] sw_rdat;
  logic          sw_match;
  logic [7:0]    sw_aindex;
  logic          grant;
  logic          yield = 0, reset = 0;
  logic          hw_req = 0, hw_we = 0;
  logic [AW-1:0] hw_addr = '0;
  logic [DW-1:0] hw_wdat = '0;
  logic          hw_gnt, hw_rvalid;
  logic [DW-1:0] hw_rdat;
  logic          ram_cs, ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdat;
  logic [DW-1:0] ram_rdat = '0;

  logic [DW-1:0] mem [1<<AW];

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] swq [$];
  logic [DW-1:0] hwq [$];
  logic [8:0]    cmpq [$];
  logic pend_sw = 0, pend_hw = 0, pend_c1 = 0, pend_c2 = 0;

  localparam logic [DW-1:0] D_A5 = {12{8'hA5}};
  localparam logic [DW-1:0] D_HW = {12{8'h3C}};
  localparam logic [DW-1:0] D_BS = {12{8'h5A}};
  localparam logic [DW-1:0] D_CP = {6{16'hBEEF}};
  localparam logic [DW-1:0] D_Y  = {12{8'h77}};

  nx_indirect_access_ram_arb dut (
    .clk(clk), .rst_n(rst_n),
    .sw_cs(sw_cs), .sw_ce(sw_ce), .sw_we(sw_we), .sw_add(sw_add), .sw_wdat(sw_wdat),
    .sw_rdat(sw_rdat), .sw_match(sw_match), .sw_aindex(sw_aindex), .grant(grant),
    .yield(yield), .reset(reset),
    .hw_req(hw_req), .hw_we(hw_we), .hw_addr(hw_addr), .hw_wdat(hw_wdat),
    .hw_gnt(hw_gnt), .hw_rvalid(hw_rvalid), .hw_rdat(hw_rdat),
    .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdat(ram_wdat),
    .ram_rdat(ram_rdat)
  );

  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
  end

  always @(posedge clk) begin
    if (ram_cs) begin
      if (ram_we) mem[ram_addr] <= ram_wdat;
      else        ram_rdat <= mem[ram_addr];
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops expected returns whenever the DUT presents read data.
  always @(negedge clk) begin
    if (!rst_n) begin
      if (pend_hw) chk("hw_rvalid_after_reset", 128'(hw_rvalid), 128'd0);
      pend_sw = 0; pend_hw = 0; pend_c1 = 0; pend_c2 = 0;
    end else begin
      if (pend_sw) begin
        if (swq.size() == 0) chk("sw_rdat_no_expect", 128'd1, 128'd0);
        else chk("sw_rdat", 128'(sw_rdat), 128'(swq.pop_front()));
      end
      if (pend_c2) begin
        if (cmpq.size() == 0) chk("cmp_no_expect", 128'd1, 128'd0);
        else chk("cmp_match_aindex", 128'({sw_match, sw_aindex}), 128'(cmpq.pop_front()));
      end
      if (hw_rvalid) begin
        if (hwq.size() == 0) chk("hw_rvalid_unexpected", 128'd1, 128'd0);
        else chk("hw_rdat", 128'(hw_rdat), 128'(hwq.pop_front()));
      end else if (pend_hw) begin
        chk("hw_rvalid_missing", 128'd0, 128'd1);
      end
      pend_c2 = pend_c1;
      pend_c1 = grant & sw_ce & ~sw_we;
      pend_sw = grant & ~sw_ce & ~sw_we;
      pend_hw = hw_gnt & ~hw_we;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sw_op(input logic we, input logic ce, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, output int waited);
    bit got = 0;
    waited = 0;
    sw_cs = 1; sw_we = we; sw_ce = ce; sw_add = a; sw_wdat = d;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (grant) got = 1;
      else waited++;
    end
    if (!got) chk("sw_grant_timeout", 128'd0, 128'd1);
    tick();
    sw_cs = 0; sw_we = 0; sw_ce = 0;
  endtask

  initial begin
    int w;
    int nhw;
    bit done;

    // Reset state
    rst_n = 0; hw_req = 1; sw_cs = 1;
    tick();
    @(negedge clk);
    chk("rst_grant", 128'(grant), 128'd0);
    chk("rst_hw_gnt", 128'(hw_gnt), 128'd0);
    chk("rst_ram_cs", 128'(ram_cs), 128'd0);
    chk("rst_outputs", 128'({sw_match, sw_aindex, hw_rvalid}), 128'd0);
    chk("rst_sw_rdat", 128'(sw_rdat), 128'd0);
    tick();
    hw_req = 0; sw_cs = 0; rst_n = 1;
    tick();

    // 1: SW write then read, no HW contention
    sw_op(1'b1, 1'b0, 9'd5, D_A5, w);
    chk("t1_write_latency", 128'(w), 128'd0);
    swq.push_back(D_A5);
    sw_op(1'b0, 1'b0, 9'd5, '0, w);
    chk("t1_read_latency", 128'(w), 128'd0);
    repeat (3) tick();
    @(negedge clk);
    chk("t1_sw_rdat_hold", 128'(sw_rdat), 128'(D_A5));

    // 2: HW burst limit
    tick();
    hw_req = 1; hw_we = 1; hw_addr = 9'd20; hw_wdat = D_HW;
    sw_cs = 1; sw_we = 1; sw_add = 9'd30; sw_wdat = D_BS;
    nhw = 0; done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (grant) begin
        done = 1;
        chk("t2_grant_excl", 128'(hw_gnt), 128'd0);
      end else if (hw_gnt) nhw++;
    end
    chk("t2_burst_done", 128'(done), 128'd1);
    chk("t2_hw_burst_count", 128'(nhw), 128'd8);
    tick();
    sw_cs = 0; sw_we = 0;
    @(negedge clk);
    chk("t2_hw_resumes", 128'(hw_gnt), 128'd1);
    tick();
    hw_req = 0; hw_we = 0;
    swq.push_back(D_BS);
    sw_op(1'b0, 1'b0, 9'd30, '0, w);
    hwq.push_back(D_HW);
    hw_req = 1; hw_addr = 9'd20;
    tick();
    hw_req = 0;

    // 3: yield / reset give SW absolute priority
    tick();
    hw_req = 1; hw_we = 1; hw_addr = 9'd40; hw_wdat = D_Y;
    sw_cs = 1; sw_we = 1; sw_add = 9'd41; sw_wdat = D_Y; yield = 1;
    @(negedge clk);
    chk("t3_yield_grant", 128'({grant, hw_gnt}), 128'b10);
    tick();
    yield = 0; reset = 1; sw_add = 9'd42;
    @(negedge clk);
    chk("t3_reset_grant", 128'({grant, hw_gnt}), 128'b10);
    tick();
    reset = 0; sw_cs = 0; sw_we = 0; hw_req = 0; hw_we = 0;

    // 4: compare hit and miss
    sw_op(1'b1, 1'b0, 9'h1F0, D_CP, w);
    cmpq.push_back({1'b1, 8'hF0});
    sw_op(1'b0, 1'b1, 9'h1F0, D_CP, w);
    cmpq.push_back({1'b0, 8'hF0});
    sw_op(1'b0, 1'b1, 9'h1F0, D_CP ^ 96'd1, w);
    repeat (3) tick();

    // 5: back-to-back HW read then SW read
    hwq.push_back(D_HW);
    hw_req = 1; hw_we = 0; hw_addr = 9'd20;
    tick();
    hw_req = 0;
    swq.push_back(D_A5);
    sw_cs = 1; sw_we = 0; sw_ce = 0; sw_add = 9'd5;
    tick();
    sw_cs = 0;
    repeat (3) tick();

    // 6: reset in the cycle after a HW read grant
    hw_req = 1; hw_we = 0; hw_addr = 9'd20;
    tick();
    rst_n = 0; sw_cs = 1;
    @(negedge clk);
    chk("t6_hw_rvalid", 128'(hw_rvalid), 128'd0);
    chk("t6_gnt_low", 128'({grant, hw_gnt, ram_cs}), 128'd0);
    tick();
    @(negedge clk);
    chk("t6_sw_rdat", 128'(sw_rdat), 128'd0);
    chk("t6_hw_rdat", 128'(hw_rdat), 128'd0);
    chk("t6_cmp_regs", 128'({sw_match, sw_aindex}), 128'd0);
    tick();
    hw_req = 0; sw_cs = 0; rst_n = 1;
    repeat (3) tick();
    @(negedge clk);
    chk("t6_no_late_rvalid", 128'(hw_rvalid), 128'd0);

    chk("queues_drained", 128'(swq.size() + hwq.size() + cmpq.size()), 128'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
